// File: rtl/vfd_scan_top.sv
// rtl/vfd_scan_top.sv - VFD scan driver fed by a write-only SPI slave frame buffer
// Optional macro VFD_DOUBLE_BUFFER_EN: front/back banks, swapped at grid-0 start after SCS rises.
module vfd_scan_top #(
   parameter int CLK_DIV   = 2,
   parameter int CHAIN_LEN = 16,
   parameter int GRIDS     = 4,
   parameter int ON_CYCLES = 64
) (
   input  logic SYS_CLK,
   input  logic SYS_RST_N,
   input  logic SSI,
   input  logic SSCK,
   input  logic SCS,
   output logic S1,
   output logic S2,
   output logic S3,
   output logic SCK,
   output logic LAT,
   output logic BLK,
   output logic PWM
);
   localparam int CB    = CHAIN_LEN / 8;
   localparam int DEPTH = GRIDS * 3 * CB;
`ifdef VFD_DOUBLE_BUFFER_EN
   localparam int NBANK = 2;
`else
   localparam int NBANK = 1;
`endif
   localparam int AW  = $clog2(NBANK * DEPTH);
   localparam int DAW = $clog2(DEPTH);
   localparam int BW  = $clog2(CHAIN_LEN);
   localparam int GW  = (GRIDS > 1) ? $clog2(GRIDS) : 1;
   localparam int CW  = $clog2(ON_CYCLES + 2 * CLK_DIV + 1);
   localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {ST_SHIFT, ST_LATCH, ST_ON} state_t;

   logic [2:0]     ssck_sync;
   logic [1:0]     ssi_sync;
   logic [1:0]     scs_sync;
   logic           ssck_rise;
   logic [2:0]     spi_bits;
   logic [7:0]     spi_shift;
   logic           wr_pend;
   logic [DAW-1:0] wr_addr;
   logic [AW-1:0]  wr_off;
   logic [AW-1:0]  rd_off;
   logic [AW-1:0]  wr_idx;
   logic [AW-1:0]  base_idx;
   logic [2:0]     bit_sel;
   logic [7:0]     mem [NBANK*DEPTH];

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic [BW-1:0]  bit_idx;
   logic [GW-1:0]  grid;
   logic [DW-1:0]  pwm_div;
   logic           pwm_q;
   logic           phase_end;

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         ssck_sync <= '0;
         ssi_sync  <= '0;
         scs_sync  <= '1;
      end else begin
         ssck_sync <= {ssck_sync[1:0], SSCK};
         ssi_sync  <= {ssi_sync[0], SSI};
         scs_sync  <= {scs_sync[0], SCS};
      end
   end

   assign ssck_rise = ssck_sync[1] & ~ssck_sync[2];

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         spi_bits  <= '0;
         spi_shift <= '0;
         wr_pend   <= 1'b0;
      end else begin
         wr_pend <= 1'b0;
         if (scs_sync[1]) begin
            spi_bits <= '0;
         end else if (ssck_rise) begin
            spi_shift <= {spi_shift[6:0], ssi_sync[1]};
            spi_bits  <= spi_bits + 3'd1;
            wr_pend   <= (spi_bits == 3'd7);
         end
      end
   end

   assign wr_idx = wr_off + AW'(wr_addr);

   // A byte completing as SCS rises is still stored before the address rewinds.
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         for (int i = 0; i < NBANK * DEPTH; i++) mem[i] <= '0;
         wr_addr <= '0;
      end else begin
         if (wr_pend) mem[wr_idx] <= spi_shift;
         if (scs_sync[1])
            wr_addr <= '0;
         else if (wr_pend)
            wr_addr <= (wr_addr == DAW'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      phase_end = 1'b0;
      SCK       = 1'b0;
      LAT       = 1'b0;
      BLK       = 1'b1;
      PWM       = 1'b0;
      case (state)
         ST_SHIFT: begin
            SCK       = (cnt >= CW'(CLK_DIV));
            phase_end = (cnt == CW'(2 * CLK_DIV - 1));
            if (phase_end && bit_idx == BW'(CHAIN_LEN - 1)) state_nx = ST_LATCH;
         end
         ST_LATCH: begin
            LAT       = 1'b1;
            phase_end = (cnt == CW'(CLK_DIV - 1));
            if (phase_end) state_nx = ST_ON;
         end
         ST_ON: begin
            BLK       = 1'b0;
            PWM       = pwm_q;
            phase_end = (cnt == CW'(ON_CYCLES - 1));
            if (phase_end) state_nx = ST_SHIFT;
         end
         default: state_nx = ST_SHIFT;
      endcase
   end

   // bit_idx parks on the last bit through LATCH/ON so the S lines hold it.
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state   <= ST_SHIFT;
         cnt     <= '0;
         bit_idx <= '0;
         grid    <= '0;
         pwm_div <= '0;
         pwm_q   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= phase_end ? '0 : cnt + 1'b1;
         if (state == ST_SHIFT && phase_end && state_nx == ST_SHIFT)
            bit_idx <= bit_idx + 1'b1;
         if (state == ST_ON && phase_end) begin
            bit_idx <= '0;
            grid    <= (grid == GW'(GRIDS - 1)) ? '0 : grid + 1'b1;
         end
         if (state == ST_ON && !phase_end) begin
            pwm_div <= (pwm_div == DW'(CLK_DIV - 1)) ? '0 : pwm_div + 1'b1;
            if (pwm_div == DW'(CLK_DIV - 1)) pwm_q <= ~pwm_q;
         end else begin
            pwm_div <= '0;
            pwm_q   <= 1'b0;
         end
      end
   end

`ifdef VFD_DOUBLE_BUFFER_EN
   logic front, scs_prev, swap_pend, frame_start;

   assign frame_start = (state == ST_ON) && phase_end && (grid == GW'(GRIDS - 1));

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         front     <= 1'b0;
         scs_prev  <= 1'b1;
         swap_pend <= 1'b0;
      end else begin
         scs_prev <= scs_sync[1];
         if (frame_start && swap_pend) begin
            front     <= ~front;
            swap_pend <= 1'b0;
         end
         if (scs_sync[1] && !scs_prev) swap_pend <= 1'b1;
      end
   end

   assign rd_off = front ? AW'(DEPTH) : '0;
   assign wr_off = front ? '0 : AW'(DEPTH);
`else
   assign rd_off = '0;
   assign wr_off = '0;
`endif

   assign base_idx = rd_off + AW'(int'(grid) * 3 * CB + int'(bit_idx) / 8);
   assign bit_sel  = 3'd7 - 3'(bit_idx);
   assign S1 = mem[base_idx][bit_sel];
   assign S2 = mem[base_idx + AW'(CB)][bit_sel];
   assign S3 = mem[base_idx + AW'(2 * CB)][bit_sel];

endmodule

// File: tb/tb_vfd_scan_top.sv
// tb/tb_vfd_scan_top.sv - directed self-checking bench for vfd_scan_top (default parameters)
// Expected values differ where VFD_DOUBLE_BUFFER_EN changes write visibility.
module tb_vfd_scan_top;
   localparam int FRAME = 520;

`ifdef VFD_DOUBLE_BUFFER_EN
   localparam logic [15:0] PB_S1 = 16'hC301;
   localparam logic [15:0] PB_S2 = 16'h0203;
   localparam logic [15:0] PB_S3 = 16'h0405;
   localparam logic [15:0] HOLD_S1 = 16'hC301;
`else
   localparam logic [15:0] PB_S1 = 16'hC331;
   localparam logic [15:0] PB_S2 = 16'h3233;
   localparam logic [15:0] PB_S3 = 16'h3435;
   localparam logic [15:0] HOLD_S1 = 16'h0001;
`endif

   logic clk = 1'b0;
   logic rst_n, ssi, ssck, scs;
   logic s1, s2, s3, sck, lat, blk, pwm;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   f;

   vfd_scan_top dut (
      .SYS_CLK(clk), .SYS_RST_N(rst_n), .SSI(ssi), .SSCK(ssck), .SCS(scs),
      .S1(s1), .S2(s2), .S3(s3), .SCK(sck), .LAT(lat), .BLK(blk), .PWM(pwm)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int k);
      while (cyc < k) tick();
   endtask

   task automatic spi_bit(input logic b);
      ssi  = b;
      ssck = 1'b0;
      repeat (4) tick();
      ssck = 1'b1;
      repeat (4) tick();
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic spi_begin();
      scs = 1'b0;
      repeat (4) tick();
   endtask

   task automatic spi_end();
      ssck = 1'b0;
      repeat (4) tick();
      scs = 1'b1;
      repeat (6) tick();
   endtask

   function automatic int next_frame();
      return ((cyc + 8) / FRAME + 1) * FRAME;
   endfunction

   // Samples each chain on every SCK-high half of a grid starting at cycle st.
   task automatic check_grid(input int st, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input string tag);
      for (int k = 0; k < 16; k++) begin
         go_to(st + 4 * k + 2);
         check($sformatf("%s_sck_b%0d", tag, k), 16'(sck), 16'd1);
         check($sformatf("%s_s1_b%0d", tag, k), 16'(s1), 16'(e1[15-k]));
         check($sformatf("%s_s2_b%0d", tag, k), 16'(s2), 16'(e2[15-k]));
         check($sformatf("%s_s3_b%0d", tag, k), 16'(s3), 16'(e3[15-k]));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ssi   = 1'b0;
      ssck  = 1'b0;
      scs   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_blk", 16'(blk), 16'd1);
      check("rst_lat", 16'(lat), 16'd0);
      check("rst_sck", 16'(sck), 16'd0);
      check("rst_pwm", 16'(pwm), 16'd0);
      check("rst_s", 16'({s3, s2, s1}), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;

      check("c0_blk", 16'(blk), 16'd1);
      check("c0_sck", 16'(sck), 16'd0);
      go_to(2);   check("c2_sck", 16'(sck), 16'd1);
      go_to(4);   check("c4_sck", 16'(sck), 16'd0);
      go_to(10);  check("c10_s", 16'({s3, s2, s1}), 16'd0);
      go_to(63);  check("c63_lat", 16'(lat), 16'd0);
      go_to(64);  check("c64_lat", 16'(lat), 16'd1);
                  check("c64_blk", 16'(blk), 16'd1);
                  check("c64_sck", 16'(sck), 16'd0);
      go_to(65);  check("c65_lat", 16'(lat), 16'd1);
      go_to(66);  check("c66_lat", 16'(lat), 16'd0);
                  check("c66_blk", 16'(blk), 16'd0);
                  check("c66_pwm", 16'(pwm), 16'd0);
      go_to(68);  check("c68_pwm", 16'(pwm), 16'd1);
      go_to(70);  check("c70_pwm", 16'(pwm), 16'd0);
      go_to(129); check("c129_blk", 16'(blk), 16'd0);
                  check("c129_pwm", 16'(pwm), 16'd1);
      go_to(130); check("c130_blk", 16'(blk), 16'd1);
                  check("c130_pwm", 16'(pwm), 16'd0);

      spi_begin();
      spi_byte(8'hA5);
      spi_end();
      f = next_frame();
      check_grid(f, 16'hA500, 16'h0000, 16'h0000, "a5");

      spi_begin();
      for (int i = 0; i < 24; i++) spi_byte(8'(i));
      spi_end();
      f = next_frame();
      check_grid(f + 130, 16'h0607, 16'h0809, 16'h0A0B, "full_g1");
      check_grid(f + 390, 16'h1213, 16'h1415, 16'h1617, "full_g3");
      check_grid(f + FRAME, 16'h0001, 16'h0203, 16'h0405, "full_wrap_g0");

      spi_begin();
      for (int i = 0; i < 25; i++) spi_byte(8'(8'h30 + i));
      spi_end();
      f = next_frame();
      check_grid(f, 16'h4831, 16'h3233, 16'h3435, "addr_wrap");

      spi_begin();
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      spi_end();
      spi_begin();
      spi_byte(8'hC3);
      spi_end();
      f = next_frame();
      check_grid(f, PB_S1, PB_S2, PB_S3, "partial_drop");

      spi_begin();
      for (int i = 0; i < 24; i++) spi_byte(8'(i));
      f = next_frame();
      check_grid(f, HOLD_S1, 16'h0203, 16'h0405, "scs_low_hold");
      spi_end();
      f = next_frame();
      check_grid(f, 16'h0001, 16'h0203, 16'h0405, "after_scs_rise");

      f = next_frame();
      go_to(f + 68);
      check("on_blk", 16'(blk), 16'd0);
      check("on_pwm", 16'(pwm), 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_blk", 16'(blk), 16'd1);
      check("mid_rst_pwm", 16'(pwm), 16'd0);
      check("mid_rst_lat", 16'(lat), 16'd0);
      check("mid_rst_sck", 16'(sck), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      check("rr_c0_s", 16'({s3, s2, s1}), 16'd0);
      check("rr_c0_blk", 16'(blk), 16'd1);
      go_to(2);  check("rr_c2_sck", 16'(sck), 16'd1);
      go_to(63); check("rr_c63_lat", 16'(lat), 16'd0);
      go_to(64); check("rr_c64_lat", 16'(lat), 16'd1);
      go_to(66); check("rr_c66_blk", 16'(blk), 16'd0);

      spi_begin();
      spi_byte(8'h80);
      spi_end();
      f = next_frame();
      check_grid(f, 16'h8000, 16'h0000, 16'h0000, "post_rst_write");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
